// File: rtl/led_panel_pkg.sv
// ----------------------------------------------------------------------------
// led_panel_pkg
// Shared constants for the LED panel Avalon-MM control/status front end:
//   - register word addresses (CTRL .. RESERVED)
//   - IRQ pending/enable bit indices
//   - CTRL FLIP bit index and VERSION constants
//   - flip FSM state encoding
// ----------------------------------------------------------------------------
package led_panel_pkg;

    localparam logic [2:0] ADDR_CTRL          = 3'd0;
    localparam logic [2:0] ADDR_IRQ           = 3'd1;
    localparam logic [2:0] ADDR_GEOMETRY      = 3'd2;
    localparam logic [2:0] ADDR_VERSION       = 3'd3;
    localparam logic [2:0] ADDR_FRAME_COUNT   = 3'd4;
    localparam logic [2:0] ADDR_FRAME_COMPARE = 3'd5;
    localparam logic [2:0] ADDR_BRIGHTNESS    = 3'd6;
    localparam logic [2:0] ADDR_RESERVED      = 3'd7;

    localparam int IRQ_VSYNC       = 0;
    localparam int IRQ_FLIP_DONE   = 1;
    localparam int IRQ_FRAME_MATCH = 2;

    localparam int CTRL_FLIP_BIT = 7;

    localparam logic [7:0] VERSION_MAJOR = 8'd2;
    localparam logic [7:0] VERSION_MINOR = 8'd0;

    typedef enum logic {
        FLIP_IDLE    = 1'b0,
        FLIP_PENDING = 1'b1
    } flip_state_e;

endpackage

// File: rtl/led_panel_ctrl_avalon_flipper.sv
// ----------------------------------------------------------------------------
// led_buffer_flipper
// v_sync rising-edge detector, flip request FSM and front/back buffer ring.
// Ports:
//   clock, reset_n   : scan clock, synchronous active-low reset
//   v_sync           : scan engine frame marker
//   flip_req         : one-cycle request from a CTRL write with FLIP=1
//   vsync_edge       : pulse in the cycle a v_sync rise is seen
//   flip_done        : pulse in the cycle a pending flip is committed
//   flip_pending     : FSM is waiting for the next edge
//   front_buffer     : buffer index being displayed
//   back_buffer      : buffer index software writes
// ----------------------------------------------------------------------------
module led_buffer_flipper
    import led_panel_pkg::*;
#(
    parameter int BUFFER_LINES = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    v_sync,
    input  logic                    flip_req,
    output logic                    vsync_edge,
    output logic                    flip_done,
    output logic                    flip_pending,
    output logic [BUFFER_LINES-1:0] front_buffer,
    output logic [BUFFER_LINES-1:0] back_buffer
);

    localparam int NUM_BUFFERS = 1 << BUFFER_LINES;
    localparam logic [BUFFER_LINES-1:0] BACK_RESET = BUFFER_LINES'(1 % NUM_BUFFERS);

    flip_state_e             state_q, state_d;
    logic                    v_sync_q, v_sync_d;
    logic [BUFFER_LINES-1:0] front_q, front_d;
    logic [BUFFER_LINES-1:0] back_q, back_d;

    assign vsync_edge   = v_sync & ~v_sync_q;
    assign flip_pending = (state_q == FLIP_PENDING);
    assign front_buffer = front_q;
    assign back_buffer  = back_q;

    // A request arriving in IDLE is only registered, even if an edge is
    // present in the same cycle; the flip is taken on the following edge.
    // The ring size is a power of two, so the natural wrap is the modulo.
    always_comb begin
        state_d   = state_q;
        front_d   = front_q;
        back_d    = back_q;
        flip_done = 1'b0;
        v_sync_d  = v_sync;
        case (state_q)
            FLIP_IDLE: begin
                if (flip_req) begin
                    state_d = FLIP_PENDING;
                end
            end
            FLIP_PENDING: begin
                if (vsync_edge) begin
                    state_d   = FLIP_IDLE;
                    front_d   = back_q;
                    back_d    = back_q + BUFFER_LINES'(1);
                    flip_done = 1'b1;
                end
            end
            default: state_d = FLIP_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= FLIP_IDLE;
            v_sync_q <= 1'b0;
            front_q  <= '0;
            back_q   <= BACK_RESET;
        end else begin
            state_q  <= state_d;
            v_sync_q <= v_sync_d;
            front_q  <= front_d;
            back_q   <= back_d;
        end
    end

endmodule

// File: rtl/led_panel_ctrl_avalon.sv
// ----------------------------------------------------------------------------
// led_panel_ctrl_avalon
// Avalon-MM control/status slave for the LED panel scan engine: buffer ring
// flip control, maskable interrupts, frame counter/compare and brightness.
// Configuration macro: LEDPANEL_FRAME_COUNTER_EN builds the frame counter,
// FRAME_COMPARE register and FRAME_MATCH interrupt source.
// Ports:
//   clock, reset_n          : scan clock, synchronous active-low reset
//   s0_address/write/read   : Avalon-MM slave, 8 word registers
//   s0_writedata/readdata   : 32-bit data, readdata registered (latency 1)
//   irq                     : level interrupt, |(pending & enable)
//   v_sync                  : frame marker from the scan engine
//   front_buffer/back_buffer: buffer ring indices
//   brightness              : global brightness to the scan engine
// ----------------------------------------------------------------------------
module led_panel_ctrl_avalon
    import led_panel_pkg::*;
#(
    parameter int DISPLAY_ROWS_LINES = 4,
    parameter int DISPLAY_COLS_LINES = 6,
    parameter int COLOR_BITS         = 8,
    parameter int BUFFER_LINES       = 1,
    parameter int BRIGHT_BITS        = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [2:0]              s0_address,
    input  logic                    s0_write,
    input  logic [31:0]             s0_writedata,
    input  logic                    s0_read,
    output logic [31:0]             s0_readdata,
    output logic                    irq,
    input  logic                    v_sync,
    output logic [BUFFER_LINES-1:0] front_buffer,
    output logic [BUFFER_LINES-1:0] back_buffer,
    output logic [BRIGHT_BITS-1:0]  brightness
);

    localparam int NUM_BUFFERS = 1 << BUFFER_LINES;
    localparam logic [31:0] GEOMETRY_WORD = {8'(NUM_BUFFERS), 8'(COLOR_BITS),
                                             8'(1 << DISPLAY_ROWS_LINES),
                                             8'(1 << DISPLAY_COLS_LINES)};
    localparam logic [31:0] VERSION_WORD = {VERSION_MAJOR, VERSION_MINOR, 16'd0};

    // A simultaneous read is dropped in favour of the write.
    logic wr_en, rd_en, flip_req;
    assign wr_en    = s0_write;
    assign rd_en    = s0_read & ~s0_write;
    assign flip_req = wr_en && (s0_address == ADDR_CTRL) && s0_writedata[CTRL_FLIP_BIT];

    logic vsync_edge, flip_done, flip_pending;

    led_buffer_flipper #(
        .BUFFER_LINES(BUFFER_LINES)
    ) u_flipper (
        .clock        (clock),
        .reset_n      (reset_n),
        .v_sync       (v_sync),
        .flip_req     (flip_req),
        .vsync_edge   (vsync_edge),
        .flip_done    (flip_done),
        .flip_pending (flip_pending),
        .front_buffer (front_buffer),
        .back_buffer  (back_buffer)
    );

    logic        frame_match;
    logic [31:0] frame_count_rd, frame_compare_rd;
    logic [2:0]  irq_implemented;

`ifdef LEDPANEL_FRAME_COUNTER_EN
    logic [31:0] frame_count_q, frame_count_d;
    logic [31:0] frame_compare_q, frame_compare_d;
    logic [31:0] frame_count_next;

    // The match compares the incremented count against the compare value
    // held before this cycle's write, so a same-cycle write is not seen.
    always_comb begin
        frame_count_next = frame_count_q + 32'd1;
        frame_count_d    = vsync_edge ? frame_count_next : frame_count_q;
        frame_compare_d  = (wr_en && (s0_address == ADDR_FRAME_COMPARE))
                           ? s0_writedata : frame_compare_q;
        frame_match      = vsync_edge && (frame_count_next == frame_compare_q);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            frame_count_q   <= '0;
            frame_compare_q <= '0;
        end else begin
            frame_count_q   <= frame_count_d;
            frame_compare_q <= frame_compare_d;
        end
    end

    assign frame_count_rd   = frame_count_q;
    assign frame_compare_rd = frame_compare_q;
    assign irq_implemented  = 3'b111;
`else
    assign frame_match      = 1'b0;
    assign frame_count_rd   = '0;
    assign frame_compare_rd = '0;
    assign irq_implemented  = 3'b011;
`endif

    logic [2:0]             irq_pending_q, irq_pending_d;
    logic [2:0]             irq_enable_q, irq_enable_d;
    logic [2:0]             irq_set;
    logic [BRIGHT_BITS-1:0] brightness_q, brightness_d;
    logic [31:0]            readdata_q, readdata_d;
    logic [31:0]            rd_mux;
    logic                   unused_writedata;

    assign unused_writedata = ^s0_writedata;

    // Sources are applied after the write-1-to-clear so a set in the same
    // cycle wins; unbuilt sources are masked out of pending and enable.
    always_comb begin
        irq_set                  = '0;
        irq_set[IRQ_VSYNC]       = vsync_edge;
        irq_set[IRQ_FLIP_DONE]   = flip_done;
        irq_set[IRQ_FRAME_MATCH] = frame_match;

        irq_pending_d = irq_pending_q;
        irq_enable_d  = irq_enable_q;
        if (wr_en && (s0_address == ADDR_IRQ)) begin
            irq_pending_d = irq_pending_q & ~s0_writedata[2:0];
            irq_enable_d  = s0_writedata[10:8] & irq_implemented;
        end
        irq_pending_d = (irq_pending_d | irq_set) & irq_implemented;

        brightness_d = brightness_q;
        if (wr_en && (s0_address == ADDR_BRIGHTNESS)) begin
            brightness_d = s0_writedata[BRIGHT_BITS-1:0];
        end
    end

    // Read multiplexer; the selected word is captured only on a read so the
    // last read value holds until the next one.
    always_comb begin
        rd_mux = '0;
        case (s0_address)
            ADDR_CTRL: begin
                rd_mux[0]             = v_sync;
                rd_mux[CTRL_FLIP_BIT] = flip_pending;
                rd_mux[15:8]          = 8'(front_buffer);
                rd_mux[23:16]         = 8'(back_buffer);
            end
            ADDR_IRQ: begin
                rd_mux[2:0]  = irq_pending_q;
                rd_mux[10:8] = irq_enable_q;
            end
            ADDR_GEOMETRY:      rd_mux = GEOMETRY_WORD;
            ADDR_VERSION:       rd_mux = VERSION_WORD;
            ADDR_FRAME_COUNT:   rd_mux = frame_count_rd;
            ADDR_FRAME_COMPARE: rd_mux = frame_compare_rd;
            ADDR_BRIGHTNESS:    rd_mux = 32'(brightness_q);
            ADDR_RESERVED:      rd_mux = '0;
            default:            rd_mux = '0;
        endcase
        readdata_d = rd_en ? rd_mux : readdata_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            irq_pending_q <= '0;
            irq_enable_q  <= '0;
            brightness_q  <= '1;
            readdata_q    <= '0;
        end else begin
            irq_pending_q <= irq_pending_d;
            irq_enable_q  <= irq_enable_d;
            brightness_q  <= brightness_d;
            readdata_q    <= readdata_d;
        end
    end

    assign s0_readdata = readdata_q;
    assign brightness  = brightness_q;
    assign irq         = |(irq_pending_q & irq_enable_q);

endmodule

// File: tb/tb_led_panel_ctrl_avalon.sv
// ----------------------------------------------------------------------------
// tb_led_panel_ctrl_avalon
// Directed bench for led_panel_ctrl_avalon with a four-entry buffer ring.
// Inputs change on the falling clock edge and outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_led_panel_ctrl_avalon;

    logic        clock;
    logic        reset_n;
    logic [2:0]  s0_address;
    logic        s0_write;
    logic [31:0] s0_writedata;
    logic        s0_read;
    logic [31:0] s0_readdata;
    logic        irq;
    logic        v_sync;
    logic [1:0]  front_buffer;
    logic [1:0]  back_buffer;
    logic [7:0]  brightness;

    int vectors    = 0;
    int miscompares = 0;

    led_panel_ctrl_avalon #(
        .BUFFER_LINES(2)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .s0_address   (s0_address),
        .s0_write     (s0_write),
        .s0_writedata (s0_writedata),
        .s0_read      (s0_read),
        .s0_readdata  (s0_readdata),
        .irq          (irq),
        .v_sync       (v_sync),
        .front_buffer (front_buffer),
        .back_buffer  (back_buffer),
        .brightness   (brightness)
    );

    // Free-running 100 MHz clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts every comparison and reports each miscompare on one line.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One-cycle bus write.
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clock);
        s0_address   = addr;
        s0_writedata = data;
        s0_write     = 1'b1;
        @(negedge clock);
        s0_write     = 1'b0;
    endtask

    // One-cycle bus read; data is returned a cycle later.
    task automatic readRegister(input logic [2:0] addr, output logic [31:0] data);
        @(negedge clock);
        s0_address = addr;
        s0_read    = 1'b1;
        @(negedge clock);
        s0_read    = 1'b0;
        data       = s0_readdata;
    endtask

    // Single-cycle v_sync high, then one idle cycle.
    task automatic pulseVsync();
        @(negedge clock);
        v_sync = 1'b1;
        @(negedge clock);
        v_sync = 1'b0;
        @(negedge clock);
    endtask

    task automatic pulseReset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    logic [31:0] rdata;
    logic [31:0] resetReads [8];

    initial begin
        reset_n      = 1'b0;
        s0_address   = '0;
        s0_write     = 1'b0;
        s0_writedata = '0;
        s0_read      = 1'b0;
        v_sync       = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Reset state of the outputs and every register.
        checkOutput("reset readdata", s0_readdata, 32'h0);
        checkOutput("reset irq", 32'(irq), 32'h0);
        checkOutput("reset front", 32'(front_buffer), 32'h0);
        checkOutput("reset back", 32'(back_buffer), 32'h1);
        checkOutput("reset brightness", 32'(brightness), 32'hFF);

        resetReads = '{32'h0001_0000, 32'h0, 32'h0408_1040, 32'h0200_0000,
                       32'h0, 32'h0, 32'h0000_00FF, 32'h0};
        for (int a = 0; a < 8; a++) begin
            readRegister(3'(a), rdata);
            checkOutput($sformatf("reset read addr%0d", a), rdata, resetReads[a]);
        end

        // Four flips walk the ring once around.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'd0, 32'h80);
            readRegister(3'd0, rdata);
            checkOutput($sformatf("flip%0d pending", i), 32'(rdata[7]), 32'h1);
            pulseVsync();
            checkOutput($sformatf("flip%0d front", i), 32'(front_buffer), 32'((i + 1) % 4));
            checkOutput($sformatf("flip%0d back", i), 32'(back_buffer), 32'((i + 2) % 4));
            readRegister(3'd0, rdata);
            checkOutput($sformatf("flip%0d cleared", i), 32'(rdata[7]), 32'h0);
        end

        // Writing 0 to FLIP does not start a request.
        applyStimulus(3'd0, 32'h0);
        readRegister(3'd0, rdata);
        checkOutput("flip write0", rdata, 32'h0001_0000);

        // FLIP write in the same cycle as a v_sync rise is not consumed there.
        @(negedge clock);
        s0_address   = 3'd0;
        s0_writedata = 32'h80;
        s0_write     = 1'b1;
        v_sync       = 1'b1;
        @(negedge clock);
        s0_write = 1'b0;
        v_sync   = 1'b0;
        @(negedge clock);
        checkOutput("samecycle front held", 32'(front_buffer), 32'h0);
        readRegister(3'd0, rdata);
        checkOutput("samecycle ctrl", rdata, 32'h0001_0080);
        pulseVsync();
        checkOutput("samecycle front next", 32'(front_buffer), 32'h1);
        checkOutput("samecycle back next", 32'(back_buffer), 32'h2);

        // Brightness write and readback; simultaneous read is ignored.
        applyStimulus(3'd6, 32'h5A);
        readRegister(3'd6, rdata);
        checkOutput("brightness read", rdata, 32'h5A);
        readRegister(3'd3, rdata);
        @(negedge clock);
        s0_address   = 3'd6;
        s0_writedata = 32'h33;
        s0_write     = 1'b1;
        s0_read      = 1'b1;
        @(negedge clock);
        s0_write = 1'b0;
        s0_read  = 1'b0;
        checkOutput("rw collision readdata", s0_readdata, 32'h0200_0000);
        checkOutput("rw collision brightness", 32'(brightness), 32'h33);
        applyStimulus(3'd7, 32'hDEAD_BEEF);
        readRegister(3'd7, rdata);
        checkOutput("reserved read", rdata, 32'h0);

        // Reset with a flip pending and irq asserted.
        applyStimulus(3'd1, 32'h0000_0103);
        checkOutput("irq cleared", 32'(irq), 32'h0);
        pulseVsync();
        checkOutput("irq vsync", 32'(irq), 32'h1);
        applyStimulus(3'd0, 32'h80);
        pulseReset();
        checkOutput("rst front", 32'(front_buffer), 32'h0);
        checkOutput("rst back", 32'(back_buffer), 32'h1);
        checkOutput("rst irq", 32'(irq), 32'h0);
        checkOutput("rst brightness", 32'(brightness), 32'hFF);
        readRegister(3'd0, rdata);
        checkOutput("rst ctrl", rdata, 32'h0001_0000);
        pulseVsync();
        checkOutput("rst no flip front", 32'(front_buffer), 32'h0);
        readRegister(3'd1, rdata);
        checkOutput("rst irq reg", rdata, 32'h1);

        pulseReset();
        applyStimulus(3'd1, 32'h0000_0707);

`ifdef LEDPANEL_FRAME_COUNTER_EN
        readRegister(3'd1, rdata);
        checkOutput("irq enables", rdata, 32'h700);
        applyStimulus(3'd5, 32'd3);
        repeat (3) pulseVsync();
        readRegister(3'd4, rdata);
        checkOutput("frame count", rdata, 32'd3);
        readRegister(3'd1, rdata);
        checkOutput("irq pending match", rdata, 32'h705);
        checkOutput("irq match level", 32'(irq), 32'h1);
        applyStimulus(3'd1, 32'h705);
        checkOutput("irq after w1c", 32'(irq), 32'h0);
        @(negedge clock);
        s0_address   = 3'd1;
        s0_writedata = 32'h701;
        s0_write     = 1'b1;
        v_sync       = 1'b1;
        @(negedge clock);
        s0_write = 1'b0;
        v_sync   = 1'b0;
        readRegister(3'd1, rdata);
        checkOutput("w1c vs set", rdata, 32'h701);
        checkOutput("w1c vs set irq", 32'(irq), 32'h1);
        readRegister(3'd4, rdata);
        checkOutput("frame count 4", rdata, 32'd4);
        @(negedge clock);
        force dut.frame_count_q = 32'hFFFF_FFFF;
        @(negedge clock);
        release dut.frame_count_q;
        pulseVsync();
        readRegister(3'd4, rdata);
        checkOutput("frame count wrap", rdata, 32'h0);
`else
        readRegister(3'd1, rdata);
        checkOutput("irq enables", rdata, 32'h300);
        applyStimulus(3'd5, 32'd3);
        repeat (3) pulseVsync();
        readRegister(3'd4, rdata);
        checkOutput("frame count absent", rdata, 32'h0);
        readRegister(3'd5, rdata);
        checkOutput("frame compare absent", rdata, 32'h0);
        readRegister(3'd1, rdata);
        checkOutput("irq pending vsync", rdata, 32'h301);
        checkOutput("irq vsync level", 32'(irq), 32'h1);
        applyStimulus(3'd1, 32'h301);
        checkOutput("irq after w1c", 32'(irq), 32'h0);
        @(negedge clock);
        s0_address   = 3'd1;
        s0_writedata = 32'h301;
        s0_write     = 1'b1;
        v_sync       = 1'b1;
        @(negedge clock);
        s0_write = 1'b0;
        v_sync   = 1'b0;
        readRegister(3'd1, rdata);
        checkOutput("w1c vs set", rdata, 32'h301);
        checkOutput("w1c vs set irq", 32'(irq), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
